// File: rtl/bsg_link_isdr_phy_pipe_if.sv
// Bundles the per-channel data, credit and training signals of the ISDR
// capture stage. The slave modport is the PHY side.
interface bsg_link_isdr_phy_pipe_if #(
  parameter int width_p    = 8,
  parameter int channels_p = 1
);
  logic                          train_en_i;
  logic [channels_p-1:0]         valid_i;
  logic [channels_p*width_p-1:0] data_i;
  logic [channels_p-1:0]         credit_i;
  logic [channels_p-1:0]         valid_o;
  logic [channels_p*width_p-1:0] data_o;
  logic [channels_p-1:0]         token_o;
  logic [channels_p-1:0]         train_lock_o;
  logic [channels_p*8-1:0]       train_err_cnt_o;

  modport slave (
    input  train_en_i, valid_i, data_i, credit_i,
    output valid_o, data_o, token_o, train_lock_o, train_err_cnt_o
  );

  modport master (
    output train_en_i, valid_i, data_i, credit_i,
    input  valid_o, data_o, token_o, train_lock_o, train_err_cnt_o
  );
endinterface

// File: rtl/bsg_link_isdr_phy_pipe.sv
// Multi-channel input SDR capture stage: per-channel register pipeline,
// credit-to-token decimation and an alternating-pattern training checker.
// Each channel is an independent lane instance.

module bsg_link_isdr_phy_lane #(
  parameter int width_p                = 8,
  parameter int stages_p               = 1,
  parameter int lg_credit_decimation_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               i_train_en,
  input  logic               i_valid,
  input  logic [width_p-1:0] i_data,
  input  logic               i_credit,
  output logic               o_valid,
  output logic [width_p-1:0] o_data,
  output logic               o_token,
  output logic               o_lock,
  output logic [7:0]         o_err_cnt
);
  // Training patterns: alternating bits with LSB 0, and its complement.
  localparam logic [width_p-1:0] PA = width_p'({((width_p+1)/2){2'b10}});
  localparam logic [width_p-1:0] PB = ~PA;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_LOCKED} state_t;

  logic [stages_p:1]              r_vld_pipe;
  logic [stages_p:1][width_p-1:0] r_dat_pipe;
  logic                           w_cap_v;
  logic [width_p-1:0]             w_cap_d;

  // Capture pipeline: stage 1 takes the pad input, each later stage the one before.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_valid;
      r_dat_pipe[1] <= i_data;
      for (int s = 2; s <= stages_p; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign w_cap_v = r_vld_pipe[stages_p];
  assign w_cap_d = r_dat_pipe[stages_p];
  // Training words must never reach the downstream FIFO; data is left ungated.
  assign o_valid = w_cap_v & ~i_train_en;
  assign o_data  = w_cap_d;

  // Credits are meaningless while the link is training.
  logic w_cred, w_wrap, r_token;
  assign w_cred = i_credit & ~i_train_en;

  if (lg_credit_decimation_p == 0) begin : g_nocnt
    assign w_wrap = 1'b1;
  end else begin : g_cnt
    logic [lg_credit_decimation_p-1:0] r_cnt;
    // Credit decimation counter; the credit that wraps it flips the token.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i)  r_cnt <= '0;
      else if (w_cred) r_cnt <= r_cnt + 1'b1;
    end
    assign w_wrap = &r_cnt;
  end

  // Token toggles on the wrapping credit.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)            r_token <= 1'b0;
    else if (w_cred && w_wrap) r_token <= ~r_token;
  end
  assign o_token = r_token;

  state_t             r_state, w_state_nxt;
  logic [width_p-1:0] r_exp, w_exp_nxt;
  logic               r_lock, w_lock_nxt;
  logic [7:0]         r_err, w_err_nxt;

  // Checker state register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_exp   <= '0;
      r_lock  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_lock  <= w_lock_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Checker next state: hunt for either pattern, then expect strict alternation.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_lock_nxt  = r_lock;
    w_err_nxt   = r_err;
    if (!i_train_en) begin
      // Leaving training keeps the error count for inspection.
      w_state_nxt = S_IDLE;
      w_lock_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SEARCH;
          w_err_nxt   = '0;
          w_lock_nxt  = 1'b0;
        end
        S_SEARCH: begin
          if (w_cap_v && (w_cap_d == PA || w_cap_d == PB)) begin
            w_state_nxt = S_LOCKED;
            w_lock_nxt  = 1'b1;
            w_exp_nxt   = ~w_cap_d;
          end
        end
        S_LOCKED: begin
          if (w_cap_v) begin
            if (w_cap_d == r_exp) begin
              w_exp_nxt = ~r_exp;
            end else begin
              if (r_err != 8'hFF) w_err_nxt = r_err + 8'd1;
              w_state_nxt = S_SEARCH;
              w_lock_nxt  = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_lock_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign o_lock    = r_lock;
  assign o_err_cnt = r_err;
endmodule

module bsg_link_isdr_phy_pipe #(
  parameter int width_p                = 8,
  parameter int channels_p             = 1,
  parameter int stages_p               = 1,
  parameter int lg_credit_decimation_p = 3
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  bsg_link_isdr_phy_pipe_if.slave  bus
);
  for (genvar c = 0; c < channels_p; c++) begin : g_lane
    bsg_link_isdr_phy_lane #(
      .width_p               (width_p),
      .stages_p              (stages_p),
      .lg_credit_decimation_p(lg_credit_decimation_p)
    ) u_lane (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .i_train_en(bus.train_en_i),
      .i_valid   (bus.valid_i[c]),
      .i_data    (bus.data_i[c*width_p +: width_p]),
      .i_credit  (bus.credit_i[c]),
      .o_valid   (bus.valid_o[c]),
      .o_data    (bus.data_o[c*width_p +: width_p]),
      .o_token   (bus.token_o[c]),
      .o_lock    (bus.train_lock_o[c]),
      .o_err_cnt (bus.train_err_cnt_o[c*8 +: 8])
    );
  end
endmodule

// File: tb/tb_bsg_link_isdr_phy_pipe.sv
// Directed bench: two channels, two-stage pipe, decimation 8 on dut_a;
// a single-channel, one-stage, undecimated dut_b for the every-credit token.
module tb_bsg_link_isdr_phy_pipe;
  logic clk_i = 1'b0;
  logic reset_n_i;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] e0, e1;

  always #5 clk_i = ~clk_i;

  bsg_link_isdr_phy_pipe_if #(.width_p(8), .channels_p(2)) bus_a ();
  bsg_link_isdr_phy_pipe_if #(.width_p(8), .channels_p(1)) bus_b ();

  bsg_link_isdr_phy_pipe #(.width_p(8), .channels_p(2), .stages_p(2),
                           .lg_credit_decimation_p(3))
    dut_a (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus_a));

  bsg_link_isdr_phy_pipe #(.width_p(8), .channels_p(1), .stages_p(1),
                           .lg_credit_decimation_p(0))
    dut_b (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one cycle of input; words accepted in normal mode go to the scoreboard.
  task automatic drive(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1);
    bus_a.valid_i = {v1, v0};
    bus_a.data_i  = {d1, d0};
    if (!bus_a.train_en_i) begin
      if (v0) q0.push_back(d0);
      if (v1) q1.push_back(d1);
    end
    tick();
  endtask

  // Scoreboard: every delivered word must be the oldest one still expected.
  always @(negedge clk_i) begin
    if (bus_a.valid_o[0]) begin
      if (q0.size() == 0) chk("sb0_spurious", {31'b0, bus_a.valid_o[0]}, 32'h0);
      else begin
        e0 = q0.pop_front();
        chk("sb0_data", {24'b0, bus_a.data_o[7:0]}, {24'b0, e0});
      end
    end
    if (bus_a.valid_o[1]) begin
      if (q1.size() == 0) chk("sb1_spurious", {31'b0, bus_a.valid_o[1]}, 32'h0);
      else begin
        e1 = q1.pop_front();
        chk("sb1_data", {24'b0, bus_a.data_o[15:8]}, {24'b0, e1});
      end
    end
  end

  initial begin
    reset_n_i = 1'b0;
    bus_a.train_en_i = 1'b0; bus_a.valid_i = '0; bus_a.data_i = '0; bus_a.credit_i = '0;
    bus_b.train_en_i = 1'b0; bus_b.valid_i = '0; bus_b.data_i = '0; bus_b.credit_i = '0;
    tick(); tick();
    chk("rst_valid", {30'b0, bus_a.valid_o}, 32'h0);
    chk("rst_data",  {16'b0, bus_a.data_o}, 32'h0);
    chk("rst_token", {30'b0, bus_a.token_o}, 32'h0);
    chk("rst_lock",  {30'b0, bus_a.train_lock_o}, 32'h0);
    chk("rst_err",   {16'b0, bus_a.train_err_cnt_o}, 32'h0);
    reset_n_i = 1'b1;

    // Latency of exactly two stages.
    drive(1'b1, 8'h3C, 1'b0, 8'h00);
    chk("lat_t1_valid", {31'b0, bus_a.valid_o[0]}, 32'h0);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("lat_t2_valid", {31'b0, bus_a.valid_o[0]}, 32'h1);
    chk("lat_t2_data",  {24'b0, bus_a.data_o[7:0]}, 32'h3C);

    // Reset mid-stream drops the in-flight words.
    drive(1'b1, 8'h11, 1'b1, 8'h22);
    drive(1'b1, 8'h33, 1'b1, 8'h44);
    chk("stream_valid", {30'b0, bus_a.valid_o}, 32'h3);
    bus_a.valid_i = '0;
    reset_n_i = 1'b0;
    tick();
    chk("rst_mid_valid", {30'b0, bus_a.valid_o}, 32'h0);
    q0.delete(); q1.delete();
    reset_n_i = 1'b1;
    tick();
    tick();
    chk("rst_mid_drained", {30'b0, bus_a.valid_o}, 32'h0);

    // Decimated token on ch0: toggles after the 8th and 16th credit.
    bus_a.credit_i = 2'b01;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 6)  chk("tok_7cred",  {30'b0, bus_a.token_o}, 32'h0);
      if (i == 7)  chk("tok_8cred",  {30'b0, bus_a.token_o}, 32'h1);
      if (i == 14) chk("tok_15cred", {30'b0, bus_a.token_o}, 32'h1);
      if (i == 15) chk("tok_16cred", {30'b0, bus_a.token_o}, 32'h0);
    end
    bus_a.credit_i = 2'b10;
    for (int i = 0; i < 8; i++) tick();
    chk("tok_ch1_indep", {30'b0, bus_a.token_o}, 32'h2);
    bus_a.credit_i = 2'b00;

    // Undecimated token toggles on every credit.
    bus_b.credit_i = 1'b1;
    tick(); chk("tok0_c1", {31'b0, bus_b.token_o}, 32'h1);
    tick(); chk("tok0_c2", {31'b0, bus_b.token_o}, 32'h0);
    tick(); chk("tok0_c3", {31'b0, bus_b.token_o}, 32'h1);
    bus_b.credit_i = 1'b0;
    tick(); chk("tok0_hold", {31'b0, bus_b.token_o}, 32'h1);

    // Training ch0 on AA,55,AA while ch1 carries ordinary data; credits ignored.
    bus_a.train_en_i = 1'b1;
    bus_a.credit_i   = 2'b11;
    drive(1'b1, 8'hAA, 1'b1, 8'h12);
    chk("trn_lock_e1", {30'b0, bus_a.train_lock_o}, 32'h0);
    drive(1'b1, 8'h55, 1'b1, 8'h34);
    chk("trn_lock_e2", {30'b0, bus_a.train_lock_o}, 32'h0);
    drive(1'b1, 8'hAA, 1'b1, 8'h56);
    chk("trn_lock_e3",  {30'b0, bus_a.train_lock_o}, 32'h1);
    chk("trn_valid_gate", {30'b0, bus_a.valid_o}, 32'h0);
    chk("trn_data_ungated", {16'b0, bus_a.data_o}, 32'h3455);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("trn_locked", {30'b0, bus_a.train_lock_o}, 32'h1);
    chk("trn_err0",   {16'b0, bus_a.train_err_cnt_o}, 32'h0);
    chk("trn_tok_ignored", {30'b0, bus_a.token_o}, 32'h2);
    bus_a.credit_i = 2'b00;

    // Expectation is now 55: one match then a repeated word mismatches.
    drive(1'b1, 8'h55, 1'b0, 8'h00);
    drive(1'b1, 8'h55, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("mis_still_lock", {30'b0, bus_a.train_lock_o}, 32'h1);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("mis_lock0", {30'b0, bus_a.train_lock_o}, 32'h0);
    chk("mis_err1",  {16'b0, bus_a.train_err_cnt_o}, 32'h1);
    drive(1'b1, 8'h55, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("relock", {30'b0, bus_a.train_lock_o}, 32'h1);
    chk("relock_err1", {16'b0, bus_a.train_err_cnt_o}, 32'h1);

    // A steady AA stream alternates relock and mismatch: >300 errors saturate.
    for (int i = 0; i < 620; i++) drive(1'b1, 8'hAA, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++)   drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("sat_err", {16'b0, bus_a.train_err_cnt_o}, 32'h00FF);
    bus_a.train_en_i = 1'b0;
    tick();
    chk("exit_lock", {30'b0, bus_a.train_lock_o}, 32'h0);
    chk("exit_err_held", {16'b0, bus_a.train_err_cnt_o}, 32'h00FF);
    bus_a.train_en_i = 1'b1;
    tick();
    chk("reenter_err_clr", {16'b0, bus_a.train_err_cnt_o}, 32'h0);
    bus_a.train_en_i = 1'b0;
    tick();

    // Normal traffic on both channels through the scoreboard.
    for (int i = 0; i < 12; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("sb0_drained", q0.size(), 32'h0);
    chk("sb1_drained", q1.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
